// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
//   Read-side consumer for a byte FIFO. Pulls DATA_WIDTH-bit entries through
//   the FIFO read port (fixed read latency of one cycle) and packs PACK
//   consecutive entries into one wide word. The word leaves on a valid/ready
//   handshake. A flush request forces out a partially filled word.
//
// Ports
//   clk            clock, rising edge
//   rstN           asynchronous reset, active-high (asserted when 1)
//   fifo_empty     FIFO empty flag
//   fifo_rd_en     read strobe to the FIFO
//   fifo_data_out  FIFO read data, valid the cycle after fifo_rd_en
//   flush          single-cycle request to emit the partial word
//   out_valid      packed word available
//   out_ready      downstream accepts the word
//   out_data       packed word, entry k in bits [k*DATA_WIDTH +: DATA_WIDTH]
//   out_count      number of valid entries in out_data while out_valid=1
//   busy           entries held, read in flight, or word waiting
module fifo_rd_packer #(
  parameter  int DATA_WIDTH = 8,
  parameter  int PACK       = 4,
  localparam int CW         = $clog2(PACK + 1)
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       fifo_empty,
  output logic                       fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]      fifo_data_out,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH*PACK-1:0] out_data,
  output logic [CW-1:0]              out_count,
  output logic                       busy
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [CW:0]   PACK_W = (CW + 1)'(PACK);
  localparam logic [CW-1:0] PACK_C = CW'(PACK);

  state_e                             state_q, state_d;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic                               rd_pend_q;
  logic                               flush_pend_q, flush_pend_d;
  logic [PACK-1:0][DATA_WIDTH-1:0]    lanes_q, lanes_d;
  logic [CW:0]                        committed;

  // Entries already captured plus the one still in flight; reads stop once
  // this reaches PACK so the word is never over-read.
  assign committed = {1'b0, cnt_q} + {{CW{1'b0}}, rd_pend_q};

  // NOTE: the lane array is reset like any other register because out_data
  // must read as zero from reset, and unfilled lanes of a partial word are 0.
  always_ff @(posedge clk or posedge rstN) begin
    if (rstN) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      rd_pend_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      lanes_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge value of every other register, independent of statement order.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_pend_q    <= fifo_rd_en;
      flush_pend_q <= flush_pend_d;
      lanes_q      <= lanes_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    lanes_d      = lanes_q;
    fifo_rd_en   = 1'b0;

    unique case (state_q)
      FILL: begin
        // Gated by rstN so no read strobe escapes while reset is held.
        fifo_rd_en = !rstN && !fifo_empty && !flush_pend_q && (committed < PACK_W);

        // A flush only matters when there is something to emit.
        if (flush && ((cnt_q != '0) || rd_pend_q)) flush_pend_d = 1'b1;

        if (rd_pend_q) begin
          for (int k = 0; k < PACK; k++) begin
            if (cnt_q == CW'(k)) lanes_d[k] = fifo_data_out;
          end
          cnt_d = cnt_q + CW'(1);
          // A capture that completes the word emits it as a normal full word,
          // absorbing any pending flush.
          if (cnt_d == PACK_C) begin
            state_d      = HOLD;
            flush_pend_d = 1'b0;
          end
        end else if (flush_pend_q && (cnt_q != '0)) begin
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (out_ready) begin
          state_d      = FILL;
          cnt_d        = '0;
          lanes_d      = '0;
          flush_pend_d = 1'b0;
        end
      end

      default: state_d = FILL;
    endcase
  end

  assign out_valid = (state_q == HOLD);
  assign out_data  = lanes_q;
  assign out_count = out_valid ? cnt_q : '0;
  assign busy      = (cnt_q != '0) || rd_pend_q || out_valid;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer
//   Self-checking bench for fifo_rd_packer (DATA_WIDTH=8, PACK=4). A queue
//   models the byte FIFO with one-cycle read latency. Directed vectors come
//   from a table; multi-cycle corners are hand-written; a random phase checks
//   the packed stream against the byte order pushed into the FIFO.
module tb_fifo_rd_packer;

  localparam int DW = 8;
  localparam int PK = 4;

  logic          clk = 1'b0;
  logic          rstN = 1'b1;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data_out = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW*PK-1:0] out_data;
  logic [2:0]    out_count;
  logic          busy;

  int total = 0;
  int bad   = 0;

  fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PK)) dut (
    .clk           (clk),
    .rstN          (rstN),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_data_out (fifo_data_out),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_count     (out_count),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- FIFO model ----------------
  logic [7:0] fq[$];   // FIFO contents
  logic [7:0] sb[$];   // bytes pushed, in order, for the random scoreboard
  bit         rd_seen;

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    sb.push_back(b);
    fifo_empty = 1'b0;
  endtask

  always @(negedge clk) begin
    rd_seen = fifo_rd_en;
    if (fifo_rd_en) check("rd_while_empty", fifo_empty, 1'b0);
  end

  always @(posedge clk) begin
    if (rd_seen && fq.size() > 0) fifo_data_out <= fq.pop_front();
    #1 fifo_empty = (fq.size() == 0);
  end

  // ---------------- random-phase monitor ----------------
  bit          mon_en = 0;
  bit          flush_seen = 0;
  bit          hold_prev = 0;
  logic [31:0] prev_data;
  logic [2:0]  prev_count;
  logic [31:0] mon_exp;
  int          mon_n;

  always @(negedge clk) begin
    if (mon_en) begin
      if (hold_prev) begin
        check("t6_hold_valid", out_valid, 1'b1);
        check("t6_hold_data", out_data, prev_data);
        check("t6_hold_count", out_count, prev_count);
      end
      if (out_valid && out_ready) begin
        mon_n   = int'(out_count);
        mon_exp = '0;
        check("t6_count_range", (mon_n >= 1 && mon_n <= PK), 1'b1);
        if (!flush_seen) check("t6_full_word", out_count, PK);
        for (int k = 0; k < PK; k++)
          if (k < mon_n && sb.size() > 0) mon_exp[8*k +: 8] = sb.pop_front();
        check("t6_data", out_data, mon_exp);
        flush_seen = 0;
      end
      hold_prev  = out_valid && !out_ready;
      prev_data  = out_data;
      prev_count = out_count;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rstN = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    fq.delete();
    fifo_empty = 1'b1;
    repeat (2) tick();
    rstN = 1'b0;
    tick();
  endtask

  task automatic wait_valid(input string name, input int max_cycles);
    int i = 0;
    while (!out_valid && i < max_cycles) begin
      tick();
      i++;
    end
    check(name, out_valid, 1'b1);
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check(name, out_valid, 1'b0);
  endtask

  typedef struct {
    logic [31:0] ent;
    int          n;
    bit          do_flush;
    logic [31:0] exp_data;
    int          exp_count;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h44332211, 4, 1'b0, 32'h44332211, 4};
    vecs[1] = '{32'h00C3B2A1, 3, 1'b1, 32'h00C3B2A1, 3};
    vecs[2] = '{32'h0000007E, 1, 1'b1, 32'h0000007E, 1};
    vecs[3] = '{32'h0000BC9A, 2, 1'b1, 32'h0000BC9A, 2};
    vecs[4] = '{32'h89ABCDEF, 4, 1'b0, 32'h89ABCDEF, 4};

    // Reset state
    repeat (2) tick();
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 32'h0);
    check("rst_count", out_count, 3'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_rd_en", fifo_rd_en, 1'b0);
    reset_dut();

    // Test 1: back-to-back reads, single-cycle valid with ready high
    out_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_rd_en_run", fifo_rd_en, 1'b1);
    end
    @(negedge clk);
    check("t1_rd_en_stop", fifo_rd_en, 1'b0);
    wait_valid("t1_valid", 10);
    check("t1_data", out_data, 32'h44332211);
    check("t1_count", out_count, 3'd4);
    tick();
    check("t1_valid_one_cycle", out_valid, 1'b0);
    out_ready = 1'b0;

    // Table-driven vectors
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < vecs[v].n; k++) push(vecs[v].ent[8*k +: 8]);
      if (vecs[v].do_flush) begin
        repeat (vecs[v].n + 3) tick();
        check("vec_no_partial", out_valid, 1'b0);
        check("vec_busy_partial", busy, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
      end
      wait_valid("vec_valid", 12);
      check("vec_data", out_data, vecs[v].exp_data);
      check("vec_count", out_count, vecs[v].exp_count);
      handshake("vec_bubble");
    end

    // Test 2: backpressure holds the word stable, no reads while held
    for (int i = 1; i <= 8; i++) push(8'(i));
    wait_valid("t2_valid1", 12);
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", out_valid, 1'b1);
      check("t2_hold_data", out_data, 32'h04030201);
      check("t2_hold_count", out_count, 3'd4);
      check("t2_hold_no_rd", fifo_rd_en, 1'b0);
      tick();
    end
    handshake("t2_bubble");
    wait_valid("t2_valid2", 12);
    check("t2_data2", out_data, 32'h08070605);
    handshake("t2_bubble2");

    // Test 3b: flush on an idle packer with an empty FIFO is ignored
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t3_idle_flush_valid", out_valid, 1'b0);
      tick();
    end
    check("t3_idle_flush_busy", busy, 1'b0);

    // Test 4: flush while the 3rd read is issued
    for (int i = 0; i < 5; i++) push(8'h31 + 8'(i));
    tick();
    tick();
    check("t4_third_rd", fifo_rd_en, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_reads_stop", fifo_rd_en, 1'b0);
    wait_valid("t4_valid", 10);
    check("t4_data", out_data, 32'h00333231);
    check("t4_count", out_count, 3'd3);
    check("t4_fifo_left", fq.size(), 2);
    handshake("t4_bubble");
    repeat (5) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_valid("t4_valid2", 10);
    check("t4_data2", out_data, 32'h00003534);
    check("t4_count2", out_count, 3'd2);
    handshake("t4_bubble2");

    // Test 5: reset mid-word (cnt=2, read in flight)
    reset_dut();
    for (int i = 0; i < 4; i++) push(8'h61 + 8'(i));
    repeat (3) tick();
    check("t5_busy_before", busy, 1'b1);
    rstN = 1'b1;
    #1;
    check("t5_rst_data", out_data, 32'h0);
    check("t5_rst_count", out_count, 3'd0);
    check("t5_rst_valid", out_valid, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_rd_en", fifo_rd_en, 1'b0);
    fq.delete();
    fifo_empty = 1'b1;
    tick();
    rstN = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h55 + 8'(i));
    wait_valid("t5_valid", 12);
    check("t5_data", out_data, 32'h58575655);
    check("t5_count", out_count, 3'd4);
    // Reset while holding a word: out_valid drops without a clock edge
    #2;
    rstN = 1'b1;
    #1;
    check("t5_async_valid", out_valid, 1'b0);
    check("t5_async_data", out_data, 32'h0);
    tick();
    rstN = 1'b0;
    tick();

    // Test 6: random fill/drain with random ready and occasional flush
    sb.delete();
    flush_seen = 0;
    hold_prev = 0;
    mon_en = 1;
    begin
      int pushed = 0;
      while (pushed < 1000) begin
        tick();
        out_ready = ($urandom_range(0, 3) != 0);
        flush = ($urandom_range(0, 24) == 0);
        if (flush) flush_seen = 1;
        if (fq.size() < 12 && $urandom_range(0, 2) != 0) begin
          push(8'($urandom));
          pushed++;
        end
      end
    end
    for (int i = 0; i < 3000 && !(sb.size() == 0 && !busy); i++) begin
      tick();
      out_ready = 1'b1;
      flush = (i % 6 == 0);
      if (flush) flush_seen = 1;
    end
    flush = 1'b0;
    tick();
    mon_en = 0;
    out_ready = 1'b0;
    check("t6_all_delivered", sb.size(), 0);
    check("t6_idle_at_end", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
Read-side consumer for the byte FIFO. It drains DATA_WIDTH-bit entries through the FIFO's read port (read_en, data_out, empty) and packs PACK consecutive entries into one wide word. Packed words leave on a valid/ready handshake toward the downstream datapath. A flush input forces out a partially filled word.

Parameters:
DATA_WIDTH, 8, width of one FIFO entry
PACK, 4, entries packed per output word (>=2)
CW, $clog2(PACK+1), width of out_count (derived, not overridable)

Ports:
clk  in  1  clock, all logic on rising edge
rstN  in  1  reset; asynchronous, active-high (asserted when 1)
fifo_empty  in  1  FIFO empty flag
fifo_rd_en  out  1  read strobe to FIFO read_en
fifo_data_out  in  DATA_WIDTH  FIFO data_out; valid the cycle after fifo_rd_en=1
flush  in  1  single-cycle request to emit the partial word
out_valid  out  1  packed word available
out_ready  in  1  downstream accepts the word
out_data  out  DATA_WIDTH*PACK  packed word; entry k in bits [k*DATA_WIDTH +: DATA_WIDTH]
out_count  out  CW  number of valid entries in out_data (1..PACK)
busy  out  1  cnt>0, read in flight, or out_valid

Behaviour:
- Reset (rstN=1, async): fifo_rd_en=0, out_valid=0, out_data=0, out_count=0, busy=0; cnt=0, rd_pend=0, flush_pend=0, state FILL. Any in-flight FIFO read is discarded.
- FIFO read latency: fixed at 1. rd_pend is fifo_rd_en registered. When rd_pend=1, fifo_data_out is captured into lane cnt and cnt increments.
- State FILL:
  - fifo_rd_en = !fifo_empty && !flush_pend && (cnt + rd_pend < PACK). This gives back-to-back reads and never over-reads past PACK.
  - Moves to HOLD when the capture makes cnt==PACK; out_count=PACK.
  - Moves to HOLD when flush_pend=1, rd_pend=0 and cnt>0; out_count=cnt.
- State HOLD:
  - out_valid=1 and fifo_rd_en=0.
  - out_data and out_count stay stable until out_ready=1.
  - On out_valid && out_ready: cnt=0, lanes cleared, flush_pend=0, back to FILL.
  - The next read may issue in the cycle after the handshake. Minimum 1 bubble between words.
- Lanes: entry 0 (first read) sits in the LSBs. Unfilled lanes of a partial word are 0.
- Flush:
  - flush in FILL with cnt>0 or rd_pend=1 sets flush_pend. New reads stop, the in-flight read is still captured, then the word is emitted.
  - flush with cnt==0 and rd_pend==0 is ignored.
  - flush in HOLD is ignored.
  - If the in-flight capture fills the word to PACK, a normal full word is emitted and flush_pend clears.
- fifo_empty asserting mid-word: reads pause and cnt holds indefinitely until more data arrives or flush.
- out_ready is ignored while out_valid=0. out_valid never drops without a handshake.
- rstN asserted in any state: immediate return to the reset values. out_valid drops asynchronously.

Test Plan:
1. PACK=4, FIFO preloaded 0x11,0x22,0x33,0x44, out_ready=1 -> fifo_rd_en high 4 consecutive cycles; out_valid one cycle with out_data=0x44332211, out_count=4.
2. 8 entries 0x01..0x08, out_ready=0 for 5 cycles after first out_valid -> out_data=0x04030201 held stable, fifo_rd_en=0 while held; after ready, second word 0x08070605.
3. 3 entries 0xA1,0xB2,0xC3, FIFO then empty, flush pulse -> out_data=0x00C3B2A1, out_count=3; empty FIFO with no data then flush -> no out_valid.
4. flush in the same cycle as 3rd fifo_rd_en (read in flight) -> 3rd entry still captured, out_count=3, no 4th read issued.
5. Reset asserted mid-word (cnt=2, rd_pend=1) -> outputs 0 immediately; after release, fresh 4 entries 0x55..0x58 give 0x58575655 with no stale lanes.
6. Random FIFO fill/drain with random out_ready, 1000 entries -> scoreboard: concatenated output bytes equal the FIFO input order; never a read while fifo_empty=1.
